// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first.
// Optional registered two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] s_sh_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;

  logic s_bit;
  logic c_next;

  // The single full-adder cell shared by every bit position.
  assign s_bit  = a_sh_reg[0] ^ b_sh_reg[0] ^ c_reg;
  assign c_next = (a_sh_reg[0] & b_sh_reg[0]) |
                  (a_sh_reg[0] & c_reg) |
                  (b_sh_reg[0] & c_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_sh_reg  <= '0;
      c_reg     <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            s_sh_reg  <= '0;
            c_reg     <= cin;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
          s_sh_reg <= {s_bit, s_sh_reg[WIDTH-1:1]};
          c_reg    <= c_next;
          cnt_reg  <= cnt_reg + CW'(1);
          // Publish only on the final bit so no partial sum is ever visible.
          if (cnt_reg == LAST) begin
            sum       <= {s_bit, s_sh_reg[WIDTH-1:1]};
            cout      <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= c_reg ^ c_next;
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations
// compared every cycle against a timing/arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic result plus accept/finish cycle stamps.
  int           cyc = 0;
  int           fin_cyc = 0;
  bit           m_run = 1'b0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_sum = '0;
  logic         p_cout = 1'b0;
  logic         p_ovf = 1'b0;
  bit           compare_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_run && !m_done && start) begin
        {p_cout, p_sum} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        p_ovf   <= (a[W-1] == b[W-1]) && (((a + b + {{(W-1){1'b0}}, cin}) >> (W-1)) != {{(W-1){1'b0}}, a[W-1]});
        m_run   <= 1'b1;
        fin_cyc <= cyc + W;
      end
      if (m_run && cyc == fin_cyc) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_sum  <= p_sum;
        m_cout <= p_cout;
        m_ovf  <= p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_run});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("sum", {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, m_sum});
      chk("cout", {31'b0, cout}, {31'b0, m_cout});
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
    end
  end

  // Issue one operation and check the published result against literals.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic eo, input bit noise);
    bit seen;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      start = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      chk("op_sum", {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, es});
      chk("op_cout", {31'b0, cout}, {31'b0, ec});
`ifdef SERIAL_ADDER_OVF_EN
      chk("op_ovf", {31'b0, ovf}, {31'b0, eo});
`endif
    end
    $display("op a=0x%02h b=0x%02h cin=%0d -> sum=0x%02h cout=%0d (exp 0x%02h %0d, ovf exp %0d)",
             ta, tb_v, tc, sum, cout, es, ec, eo);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rs;
    logic         rc, rco, ro;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_sum", {{(32-W){1'b0}}, sum}, 32'h0);
      chk("idle_cout", {31'b0, cout}, 32'd0);
    end

    // Busy lasts exactly W cycles and done follows once.
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("lat_busy", {31'b0, busy}, 32'd1);
      chk("lat_nodone", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    chk("lat_done", {31'b0, done}, 32'd1);
    chk("lat_busy_off", {31'b0, busy}, 32'd0);
    chk("lat_sum", {{(32-W){1'b0}}, sum}, 32'h10);
    chk("lat_cout", {31'b0, cout}, 32'd0);
    $display("op a=0x0f b=0x01 cin=0 -> sum=0x%02h cout=%0d", sum, cout);
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd0);

    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);

    // Start pulsed at E3 with different operands must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h3C; b = 8'h5A; cin = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 4 * W; i++) begin
        if (done) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      chk("ign_done_seen", {31'b0, seen}, 32'd1);
      chk("ign_sum", {{(32-W){1'b0}}, sum}, 32'h97);
      chk("ign_cout", {31'b0, cout}, 32'd0);
      $display("op a=0x3c b=0x5a cin=1 (start at E3 ignored) -> sum=0x%02h cout=%0d", sum, cout);
    end

    // Reset mid-operation clears everything immediately.
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {{(32-W){1'b0}}, sum}, 32'h0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    $display("reset mid-op -> busy=%0d done=%0d sum=0x%02h cout=%0d", busy, done, sum, cout);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    // Randomized operations with noise on start/operands while busy.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      {rco, rs} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ro = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, rc, rs, rco, ro, 1'b1);
    end

    repeat (2) @(negedge clk);
    compare_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
